// File: rtl/cpu_div_sequencer_if.sv
// cpu_div_sequencer_if: execute-stage request, divider handshake, writeback and
// hazard-lookup signals of the divide sequencer, bundled as one interface.
//   slave  : sequencer view (accepts requests, drives the divider and writeback)
//   master : environment view (execute stage, divider, writeback port, scoreboard)
// Signals:
//   req_valid/req_ready/req_op/req_a/req_b/req_dest  op request from execute
//   flush                                            discard op not yet written back
//   div_ready/p3_div_start/p3_numerator/p3_denominator/
//   p3_latent_dest/p3_div_sign/p3_div_mod            divider issue side
//   div_valid/div_result                             divider single-cycle result
//   wb_valid/wb_dest/wb_data/wb_grant                writeback handshake
//   rs1_sel/rs2_sel/hazard                           scoreboard lookup
interface cpu_div_sequencer_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [RW-1:0]   req_dest;
    logic            flush;

    logic            div_ready;
    logic            p3_div_start;
    logic [XLEN-1:0] p3_numerator;
    logic [XLEN-1:0] p3_denominator;
    logic [RW-1:0]   p3_latent_dest;
    logic            p3_div_sign;
    logic            p3_div_mod;
    logic            div_valid;
    logic [XLEN-1:0] div_result;

    logic            wb_valid;
    logic [RW-1:0]   wb_dest;
    logic [XLEN-1:0] wb_data;
    logic            wb_grant;

    logic [RW-1:0]   rs1_sel;
    logic [RW-1:0]   rs2_sel;
    logic            hazard;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dest, flush,
        input  div_ready, div_valid, div_result, wb_grant, rs1_sel, rs2_sel,
        output req_ready, p3_div_start, p3_numerator, p3_denominator,
        output p3_latent_dest, p3_div_sign, p3_div_mod,
        output wb_valid, wb_dest, wb_data, hazard
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_dest, flush,
        output div_ready, div_valid, div_result, wb_grant, rs1_sel, rs2_sel,
        input  req_ready, p3_div_start, p3_numerator, p3_denominator,
        input  p3_latent_dest, p3_div_sign, p3_div_mod,
        input  wb_valid, wb_dest, wb_data, hazard
    );
endinterface

// File: rtl/cpu_div_sequencer.sv
// cpu_div_sequencer: front-end controller between execute and a 32-bit iterative
// unsigned divider. Accepts DIV/DIVU/MOD/MODU, converts signed operands to
// magnitude + result sign, runs one op at a time through the divider handshake,
// holds the result for writeback and flags RAW hazards on the pending dest.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-low reset
//   bus    cpu_div_sequencer_if.slave (request, divider, writeback, hazard)
// Optional feature macro: CPU_DIV_ZERO_FASTPATH_EN -- divide-by-zero ops bypass
// the divider and land in writeback the cycle after accept.
module cpu_div_sequencer (
    input  logic               clock,
    input  logic               reset,
    cpu_div_sequencer_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_num;
    logic [XLEN-1:0] r_den;
    logic [XLEN-1:0] r_wb_data;
    logic [RW-1:0]   r_dest;
    logic            r_sign;
    logic            r_mod;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_b_zero;
    logic            w_res_sign;
    logic            w_accept;
    logic            w_pending;
    logic            w_src_hit;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    // Operand conditioning: magnitudes and the sign the divider must apply.
    assign w_signed = ~bus.req_op[0];
    assign w_a_neg  = w_signed & bus.req_a[XLEN-1];
    assign w_b_neg  = w_signed & bus.req_b[XLEN-1];
    assign w_b_zero = (bus.req_b == '0);
    assign w_a_mag  = w_a_neg ? (~bus.req_a + XLEN'(1)) : bus.req_a;
    assign w_b_mag  = w_b_neg ? (~bus.req_b + XLEN'(1)) : bus.req_b;
    // Quotient sign is suppressed on /0 so the all-ones quotient survives;
    // remainder always follows the dividend.
    assign w_res_sign = bus.req_op[1] ? w_a_neg
                      : (w_signed & (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]) & ~w_b_zero);

    // Handshake outputs; reset term keeps req_ready low while reset is held.
    assign bus.req_ready    = reset & (r_state == S_IDLE) & ~bus.flush;
    assign w_accept         = bus.req_valid & bus.req_ready;
    assign bus.p3_div_start = (r_state == S_ISSUE) & bus.div_ready & ~bus.flush;

    assign bus.p3_numerator   = r_num;
    assign bus.p3_denominator = r_den;
    assign bus.p3_latent_dest = r_dest;
    assign bus.p3_div_sign    = r_sign;
    assign bus.p3_div_mod     = r_mod;

    assign bus.wb_valid = (r_state == S_WB);
    assign bus.wb_dest  = r_dest;
    assign bus.wb_data  = r_wb_data;

    // Scoreboard: only ops that will still write back count as pending.
    assign w_pending  = (r_state == S_ISSUE) | (r_state == S_BUSY) | (r_state == S_WB);
    assign w_src_hit  = (bus.rs1_sel == r_dest) | (bus.rs2_sel == r_dest);
    assign bus.hazard = w_pending & (r_dest != '0) & w_src_hit;

    // Sequencer state and operand/result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_den     <= '0;
            r_wb_data <= '0;
            r_dest    <= '0;
            r_sign    <= 1'b0;
            r_mod     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num  <= w_a_mag;
                        r_den  <= w_b_mag;
                        r_sign <= w_res_sign;
                        r_mod  <= bus.req_op[1];
                        r_dest <= bus.req_dest;
`ifdef CPU_DIV_ZERO_FASTPATH_EN
                        if (w_b_zero) begin
                            r_wb_data <= bus.req_op[1] ? bus.req_a : '1;
                            r_state   <= (bus.req_dest != '0) ? S_WB : S_IDLE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
`else
                        r_state <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (bus.div_ready) begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        // A result arriving with the flush is simply dropped.
                        r_state <= bus.div_valid ? S_IDLE : S_DRAIN;
                    end else if (bus.div_valid) begin
                        r_wb_data <= bus.div_result;
                        r_state   <= (r_dest != '0) ? S_WB : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (bus.div_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WB: begin
                    if (bus.flush || bus.wb_grant) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_div_sequencer.sv
// tb_cpu_div_sequencer: randomized + directed self-checking bench for
// cpu_div_sequencer. Results are checked against a signed/unsigned arithmetic
// reference; an in-bench divider stub answers the start handshake.
module tb_cpu_div_sequencer;
    logic clock = 1'b0;
    logic reset;

    cpu_div_sequencer_if bus ();

    cpu_div_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int n_starts = 0;
    int stub_lat = 3;
    int spur_req = 0;
    int spur_done = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of a RISC-V style divide/remainder.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Unsigned iterative divider stand-in: unsigned op then optional negate.
    function automatic logic [31:0] stub_calc(input logic [31:0] num, input logic [31:0] den,
                                              input logic sgn, input logic md);
        logic [31:0] r;
        if (den == 32'd0) r = md ? num : 32'hFFFF_FFFF;
        else              r = md ? (num % den) : (num / den);
        return sgn ? (~r + 32'd1) : r;
    endfunction

    // Divider stub: samples start at the edge, answers stub_lat cycles later.
    initial begin
        int cnt;
        logic [31:0] res;
        logic started;
        cnt = 0;
        res = '0;
        bus.div_ready  = 1'b1;
        bus.div_valid  = 1'b0;
        bus.div_result = '0;
        forever begin
            @(posedge clock);
            started = bus.p3_div_start;
            if (started) begin
                cnt = stub_lat;
                res = stub_calc(bus.p3_numerator, bus.p3_denominator, bus.p3_div_sign, bus.p3_div_mod);
                n_starts++;
            end
            #1;
            bus.div_valid = 1'b0;
            if (spur_req != spur_done) begin
                spur_done      = spur_req;
                bus.div_valid  = 1'b1;
                bus.div_result = 32'hDEAD_BEEF;
            end else if (started) begin
                bus.div_ready = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.div_valid  = 1'b1;
                    bus.div_result = res;
                    bus.div_ready  = 1'b1;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // One complete op; entered and left on a negedge with the sequencer idle.
    // mode: 0 rs1 hits dest, 1 rs2 hits dest, 2 no source hits.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input int mode, input int gw, input logic use_flush);
        logic [31:0] exp, exp_num, exp_den;
        logic signed [31:0] sa, sb;
        logic exp_sign, exp_hz, fast, stable;
        int s0, cyc;
        sa = a;
        sb = b;
        exp = ref_div(op, a, b);
        exp_num = (!op[0] && sa < 0) ? 32'(-sa) : a;
        exp_den = (!op[0] && sb < 0) ? 32'(-sb) : b;
        exp_sign = op[1] ? (!op[0] && sa < 0)
                         : (!op[0] && ((sa < 0) != (sb < 0)) && b != 32'd0);
        exp_hz = (dest != 5'd0) && (mode != 2);
`ifdef CPU_DIV_ZERO_FASTPATH_EN
        fast = (b == 32'd0);
`else
        fast = 1'b0;
`endif
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_dest  = dest;
        bus.rs1_sel   = (mode == 0) ? dest : 5'(dest + 5'd1);
        bus.rs2_sel   = (mode == 1) ? dest : 5'(dest + 5'd2);
        #1;
        chk_eq("accept_ready", bus.req_ready, 1);
        s0 = n_starts;
        @(negedge clock);
        bus.req_valid = 1'b0;
        #1;
        chk_eq("hazard_inflight", bus.hazard, exp_hz);
        if (fast) begin
            chk_eq("fast_wb_valid", bus.wb_valid, dest != 5'd0);
            chk_eq("fast_no_start", bus.p3_div_start, 0);
        end else begin
            chk_eq("p3_numerator", bus.p3_numerator, exp_num);
            chk_eq("p3_denominator", bus.p3_denominator, exp_den);
            chk_eq("p3_sign", bus.p3_div_sign, exp_sign);
            chk_eq("p3_mod", bus.p3_div_mod, op[1]);
            chk_eq("p3_dest", bus.p3_latent_dest, dest);
            chk_eq("issue_start", bus.p3_div_start, bus.div_ready);
        end
        cyc = 0;
        while (!bus.wb_valid && !bus.req_ready && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        chk_eq("op_timeout", cyc < 300, 1);
        if (dest != 5'd0) begin
            chk_eq("wb_valid", bus.wb_valid, 1);
            chk_eq("wb_data", bus.wb_data, exp);
            chk_eq("wb_dest", bus.wb_dest, dest);
            chk_eq("hazard_wb", bus.hazard, exp_hz);
            stable = 1'b1;
            repeat (gw) begin
                @(negedge clock);
                if (!bus.wb_valid || bus.req_ready || bus.wb_data !== exp || bus.wb_dest !== dest)
                    stable = 1'b0;
            end
            chk_eq("wb_hold", stable, 1);
            if (use_flush) bus.flush = 1'b1;
            else           bus.wb_grant = 1'b1;
            @(negedge clock);
            bus.flush    = 1'b0;
            bus.wb_grant = 1'b0;
            #1;
            chk_eq("post_wb_valid", bus.wb_valid, 0);
            chk_eq("post_wb_ready", bus.req_ready, 1);
        end else begin
            chk_eq("dest0_no_wb", bus.wb_valid, 0);
            chk_eq("dest0_ready", bus.req_ready, 1);
        end
        chk_eq("start_count", 32'(n_starts - s0), (fast ? 32'd0 : 32'd1));
    endtask

    initial begin
        int cyc, s0, dv, rr, sel, mode;
        logic saw_wb;
        logic [1:0] op;
        logic [31:0] a, b;
        logic [4:0] dest;

        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_dest  = '0;
        bus.flush     = 1'b0;
        bus.wb_grant  = 1'b0;
        bus.rs1_sel   = '0;
        bus.rs2_sel   = '0;
        #12;
        chk_eq("rst_req_ready", bus.req_ready, 0);
        chk_eq("rst_start", bus.p3_div_start, 0);
        chk_eq("rst_wb_valid", bus.wb_valid, 0);
        chk_eq("rst_hazard", bus.hazard, 0);
        chk_eq("rst_numerator", bus.p3_numerator, 0);
        chk_eq("rst_wb_data", bus.wb_data, 0);
        chk_eq("rst_wb_dest", bus.wb_dest, 0);
        @(negedge clock);
        reset = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk_eq("idle_flush_ready", bus.req_ready, 0);
        bus.flush = 1'b0;
        #1;
        chk_eq("idle_ready", bus.req_ready, 1);
        @(negedge clock);

        // Directed cases
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 2, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 1, 1'b0);
        do_op(2'b11, 32'd7, 32'd2, 5'd7, 0, 0, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 2, 0, 1'b0);
        do_op(2'b01, 32'd5, 32'd0, 5'd10, 0, 0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd11, 0, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, 1, 0, 1'b0);
        do_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd13, 0, 10, 1'b0);
        do_op(2'b01, 32'd1000, 32'd33, 5'd14, 0, 3, 1'b1);

        // Flush while the divider is working: drain and drop.
        stub_lat = 6;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        bus.req_dest  = 5'd3;
        bus.rs1_sel   = 5'd3;
        @(negedge clock);
        bus.req_valid = 1'b0;
        s0 = n_starts;
        cyc = 0;
        while (n_starts == s0 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk_eq("flush_start_seen", 32'(n_starts - s0), 1);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        #1;
        chk_eq("drain_ready", bus.req_ready, 0);
        chk_eq("drain_hazard", bus.hazard, 0);
        dv = -1;
        rr = -1;
        saw_wb = 1'b0;
        cyc = 0;
        while (rr < 0 && cyc < 50) begin
            if (bus.wb_valid) saw_wb = 1'b1;
            if (bus.req_ready) rr = cyc;
            else begin
                if (bus.div_valid) dv = cyc;
                @(negedge clock);
                cyc++;
            end
        end
        chk_eq("drain_no_wb", saw_wb, 0);
        chk_eq("drain_ready_lat", 32'(rr - dv), 1);
        stub_lat = 3;
        do_op(2'b00, 32'd77, 32'hFFFF_FFF5, 5'd4, 0, 1, 1'b0);

        // Unexpected divider result while idle is ignored.
        spur_req++;
        repeat (3) @(negedge clock);
        chk_eq("spur_no_wb", bus.wb_valid, 0);
        chk_eq("spur_ready", bus.req_ready, 1);

        // Asynchronous reset in the middle of a divide.
        stub_lat = 8;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_a     = 32'd50;
        bus.req_b     = 32'd3;
        bus.req_dest  = 5'd7;
        bus.rs1_sel   = 5'd7;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk_eq("busy_hazard", bus.hazard, 1);
        reset = 1'b0;
        #1;
        chk_eq("arst_ready", bus.req_ready, 0);
        chk_eq("arst_hazard", bus.hazard, 0);
        chk_eq("arst_wb_valid", bus.wb_valid, 0);
        chk_eq("arst_start", bus.p3_div_start, 0);
        chk_eq("arst_numerator", bus.p3_numerator, 0);
        chk_eq("arst_dest", bus.p3_latent_dest, 0);
        @(negedge clock);
        reset = 1'b1;
        stub_lat = 3;
        do_op(2'b01, 32'd9, 32'd4, 5'd0, 0, 0, 1'b0);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                a = 32'($urandom_range(0, 40)) - 32'd20;
                b = 32'($urandom_range(0, 10)) - 32'd5;
            end
            dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mode = $urandom_range(0, 2);
            stub_lat = $urandom_range(1, 5);
            do_op(op, a, b, dest, mode, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_div_sequencer.md
Name: cpu_div_sequencer

Overview:
- Front-end controller between the execute stage and the 32-bit iterative unsigned divider.
- Accepts DIV/DIVU/MOD/MODU requests and converts signed operands to magnitude plus result sign. Sequences one operation at a time through the divider handshake.
- Captures the one-cycle divider result and holds it until the writeback port grants it.
- Provides a scoreboard hazard flag for the pending destination register, and a pipeline flush.

Parameters:
- none

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents a divide op
- req_ready  out  1  sequencer accepts op this cycle
- req_op  in  2  00=DIV signed, 01=DIVU, 10=MOD signed, 11=MODU
- req_a  in  32  dividend
- req_b  in  32  divisor
- req_dest  in  5  destination register
- flush  in  1  discard any op not yet written back
- div_ready  in  1  divider idle
- p3_div_start  out  1  start pulse to divider
- p3_numerator  out  32  |a|
- p3_denominator  out  32  |b|
- p3_latent_dest  out  5  dest tag
- p3_div_sign  out  1  negate result
- p3_div_mod  out  1  1=remainder
- div_valid  in  1  divider result valid (single cycle)
- div_result  in  32  divider result
- wb_valid  out  1  result waiting for writeback
- wb_dest  out  5  result register
- wb_data  out  32  result data
- wb_grant  in  1  writeback port takes result this cycle
- rs1_sel  in  5  consumer source register 1
- rs2_sel  in  5  consumer source register 2
- hazard  out  1  rs1/rs2 matches pending nonzero dest

Behaviour:
- States: IDLE, ISSUE, BUSY, DRAIN, WB.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: req_ready, p3_div_start, wb_valid and hazard are 0; data and tag outputs are 0.
- IDLE:
  - req_ready = !flush.
  - On req_valid && req_ready, register operands, op and dest, then go to ISSUE.
- Operand conversion (registered at accept):
  - signed = !req_op[0].
  - p3_numerator = signed && a[31] ? -a : a. p3_denominator likewise from b.
  - p3_div_mod = req_op[1].
  - DIV sign = signed && (a[31]^b[31]) && (b!=0).
  - MOD sign = signed && a[31].
  - Consequences: divide-by-zero gives 0xFFFFFFFF for DIV/DIVU and a for MOD/MODU; 0x80000000 / -1 gives 0x80000000, and MOD gives 0.
- ISSUE:
  - p3_div_start = div_ready && !flush, combinational and asserted for exactly one cycle.
  - Then go to BUSY.
  - flush in ISSUE: go to IDLE with no start.
- BUSY:
  - Wait for div_valid, then capture div_result.
  - If dest != 0, go to WB. If dest == 0, go to IDLE (result dropped).
  - flush in BUSY, or the same cycle as div_valid: go to DRAIN, or directly to IDLE if div_valid is high in that same cycle.
- DRAIN:
  - Wait for div_valid, discard the result, go to IDLE.
  - req_ready=0. hazard=0.
- WB:
  - wb_valid=1; wb_dest/wb_data held stable until wb_grant.
  - wb_grant: go to IDLE, with req_ready asserted the following cycle.
  - flush in WB: drop the result, go to IDLE; wb_grant is ignored in that cycle.
- hazard:
  - Asserted in ISSUE, BUSY or WB when the pending dest != 0 and (rs1_sel == dest || rs2_sel == dest).
  - Combinational from the registered dest.
- Only one op in flight; req_ready=0 in every non-IDLE state.
- Latency: accept at cycle T, start at T+1 if the divider is ready; wb_valid the cycle after div_valid.
- Unexpected div_valid in IDLE/ISSUE/WB is ignored.

Optional Feature:
- Macro: CPU_DIV_ZERO_FASTPATH_EN.
- Defined:
  - An accepted op with b==0 bypasses the divider and goes straight to WB (or IDLE if dest==0) on the next cycle.
  - wb_data = 0xFFFFFFFF for DIV/DIVU, a for MOD/MODU.
  - p3_div_start is never pulsed for such an op.
- Undefined: divide-by-zero goes through the divider with the sign rules above, producing identical values at about 33 cycles of latency.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2, dest=5 -> p3_numerator=7, p3_denominator=2, sign=1; wb_data=0xFFFFFFFD, wb_dest=5; hazard=1 with rs1_sel=5 until wb_grant.
- MOD a=-7, b=2 -> wb_data=0xFFFFFFFF; MODU a=7, b=2 -> wb_data=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> wb_data=0x80000000; DIVU a=5, b=0 -> wb_data=0xFFFFFFFF (fast path: wb_valid 1 cycle after accept, no start pulse).
- flush during BUSY -> DRAIN; following div_valid produces no wb_valid; req_ready returns the cycle after div_valid; a new op then completes correctly.
- wb_grant held low 10 cycles in WB -> wb_data/wb_dest stable, req_ready=0 throughout; grant -> IDLE next cycle.
- Async reset asserted mid-BUSY -> immediate IDLE with all outputs 0; dest=0 op completes without wb_valid.
